mem_host_ctrl: RTL

Byte-stream command front end that drives the 16x8 DFF scratch RAM as its sole initiator. It accepts commands over a valid/ready byte channel and issues single writes, single reads, wrapping burst reads and block fills on the RAM port. It returns read bytes over a valid/ready response channel. It sits between the chip's byte I/O pins and the RAM, and owns all RAM address, write-enable and data sequencing.

---
 rtl/mem_host_pkg.sv | 28 ++
 rtl/mem_host_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mem_host_pkg.sv
// Shared types for the byte-stream RAM host controller: header opcodes,
// FSM states and header field positions.
package mem_host_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_BURST = 2'b10,
    OP_FILL  = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ARG,
    S_WR,
    S_FILL,
    S_RD_ISSUE,
    S_RD_CAP,
    S_RSP
  } state_e;

  localparam int HDR_OP_MSB   = 7;
  localparam int HDR_OP_LSB   = 6;
  localparam int HDR_RSV_MSB  = 5;
  localparam int HDR_RSV_LSB  = 4;
  localparam int HDR_ADDR_LSB = 0;

endpackage

// File: rtl/mem_host_ctrl.sv
// Command front end for the scratch RAM: decodes header/argument bytes and
// sequences single writes, single reads, wrapping burst reads and block fills.
module mem_host_ctrl
  import mem_host_pkg::*;
#(
  parameter  int RAM_BYTES = 16,
  localparam int ADDR_W    = $clog2(RAM_BYTES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_data,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(RAM_BYTES - 1);
  localparam logic [ADDR_W:0]   REM_ONE   = (ADDR_W + 1)'(1);

  state_e              state_q, state_d;
  opcode_e             op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     remaining_q;
  logic [ADDR_W-1:0]   fill_cnt_q;
  logic                ready_q;

  logic                cmd_fire;
  logic                rsp_fire;
  opcode_e             hdr_op;
  logic                hdr_bad;
  logic [ADDR_W-1:0]   hdr_addr;

  assign cmd_fire = cmd_valid && ready_q;
  assign rsp_fire = rsp_valid && rsp_ready;
  assign hdr_op   = opcode_e'(cmd_data[HDR_OP_MSB:HDR_OP_LSB]);
  assign hdr_bad  = |cmd_data[HDR_RSV_MSB:HDR_RSV_LSB];
  assign hdr_addr = cmd_data[HDR_ADDR_LSB +: ADDR_W];

  assign cmd_ready = ready_q;
  assign busy      = (state_q != S_IDLE);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire && !hdr_bad)
          state_d = (hdr_op == OP_READ) ? S_RD_ISSUE : S_GET_ARG;
      end
      S_GET_ARG: begin
        if (cmd_fire) begin
          unique case (op_q)
            OP_WRITE: state_d = S_WR;
            OP_FILL:  state_d = S_FILL;
            default:  state_d = S_RD_ISSUE;
          endcase
        end
      end
      S_WR:       state_d = S_IDLE;
      S_FILL:     if (fill_cnt_q == '0) state_d = S_IDLE;
      S_RD_ISSUE: state_d = S_RD_CAP;
      S_RD_CAP:   state_d = S_RSP;
      S_RSP: begin
        if (rsp_fire)
          state_d = (remaining_q == REM_ONE) ? S_IDLE : S_RD_ISSUE;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      op_q        <= OP_WRITE;
      addr_q      <= '0;
      remaining_q <= '0;
      fill_cnt_q  <= '0;
      err         <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
    end else begin
      // Registered from the next state so cmd_ready has no path from cmd_valid.
      ready_q <= (state_d == S_IDLE) || (state_d == S_GET_ARG);
      mem_we  <= (state_d == S_WR) || (state_d == S_FILL);

      unique case (state_q)
        S_IDLE: begin
          if (cmd_fire) begin
            if (hdr_bad) begin
              err <= 1'b1;
            end else begin
              op_q        <= hdr_op;
              addr_q      <= hdr_addr;
              mem_addr    <= hdr_addr;
              remaining_q <= REM_ONE;
            end
          end
        end
        S_GET_ARG: begin
          if (cmd_fire) begin
            mem_addr    <= addr_q;
            mem_wdata   <= cmd_data;
            fill_cnt_q  <= FILL_LAST;
            remaining_q <= {1'b0, cmd_data[ADDR_W-1:0]} + REM_ONE;
          end
        end
        S_FILL: begin
          if (fill_cnt_q != '0) begin
            mem_addr   <= mem_addr + ADDR_ONE;
            fill_cnt_q <= fill_cnt_q - ADDR_ONE;
          end
        end
        S_RD_CAP: begin
          rsp_data  <= mem_rdata;
          rsp_valid <= 1'b1;
        end
        S_RSP: begin
          if (rsp_fire) begin
            rsp_valid   <= 1'b0;
            remaining_q <= remaining_q - REM_ONE;
            if (remaining_q != REM_ONE) begin
              addr_q   <= addr_q + ADDR_ONE;
              mem_addr <= addr_q + ADDR_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
